parking_gate_ctrl: RTL and testbench

Front-end gate controller that sits directly upstream of the parking occupancy counter. It debounces the entry and exit loop sensors and reads the badge reader. It sequences the two barriers and emits the single-cycle `car_entered` / `car_exited` / `is_uni_car_*` events the counter consumes, gated by the counter's space flags. It also generates the `hour_tick` pulse that advances the counter's capacity schedule.

---
 rtl/parking_gate_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate front end: loop debounce, badge-based entry sequencing, exit
// sequencing and hour tick. Define PARKING_GATE_TIMEOUT_EN to close an open barrier after OPEN_TIMEOUT.

module parking_gate_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synced samples that disagree with filt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != filt) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE      = 4,
  parameter int BADGE_WAIT    = 32,
  parameter int OPEN_TIMEOUT  = 64,
  parameter int CLKS_PER_HOUR = 3600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       entry_loop,
  input  logic       exit_loop,
  input  logic       entry_pass,
  input  logic       exit_pass,
  input  logic       badge_valid,
  input  logic       badge_uni,
  input  logic       exit_uni,
  input  logic       uni_space_ok,
  input  logic       space_ok,
  output logic       entry_open,
  output logic       exit_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_reject,
  output logic       hour_tick,
  output logic [4:0] hour
);
  localparam int BW_W = $clog2(BADGE_WAIT + 1);
  localparam int OT_W = $clog2(OPEN_TIMEOUT + 1);
  localparam int PS_W = $clog2(CLKS_PER_HOUR + 1);

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  if (DEBOUNCE < 2 || BADGE_WAIT < 1 || CLKS_PER_HOUR < 2) begin : g_param_check
    $error("parking_gate_ctrl: DEBOUNCE>=2, BADGE_WAIT>=1, CLKS_PER_HOUR>=2 required");
  end

  typedef enum logic [2:0] {
    E_IDLE, E_WAIT_BADGE, E_OPEN, E_EMIT, E_CLOSE, E_HOLD
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE, X_OPEN, X_EMIT, X_CLOSE
  } exit_state_t;

  logic              entry_filt;
  logic              exit_filt;
  logic              entry_pass_q;
  logic              exit_pass_q;
  logic              entry_rise;
  logic              exit_rise;
  logic              started;
  entry_state_t      ent_state;
  exit_state_t       ext_state;
  logic [BW_W-1:0]   ent_wait_cnt;
  logic [OT_W-1:0]   ent_open_cnt;
  logic [OT_W-1:0]   ext_open_cnt;
  logic              ent_uni;
  logic              ext_uni;
  logic              decide_uni;
  logic              decide_ok;
  logic              entry_emit_nxt;
  logic              exit_emit_nxt;
  logic [PS_W-1:0]   presc;
  logic              presc_wrap;
  logic              tick_pend;

  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (entry_loop),
    .filt (entry_filt)
  );

  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (exit_loop),
    .filt (exit_filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_pass_q <= 1'b0;
      exit_pass_q  <= 1'b0;
    end else begin
      entry_pass_q <= entry_pass;
      exit_pass_q  <= exit_pass;
    end
  end

  assign entry_rise = entry_pass & ~entry_pass_q;
  assign exit_rise  = exit_pass & ~exit_pass_q;

  // Class and space decision taken in the badge/timeout cycle
  assign decide_uni = badge_valid & badge_uni;
  assign decide_ok  = decide_uni ? uni_space_ok : space_ok;

  // Predict next-cycle EMIT so the hour tick can step aside from car events
  assign entry_emit_nxt = started & ~start & (ent_state == E_OPEN) & entry_rise;
  assign exit_emit_nxt  = started & ~start & (ext_state == X_OPEN) & exit_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_state          <= E_IDLE;
      ent_wait_cnt       <= '0;
      ent_open_cnt       <= '0;
      ent_uni            <= 1'b0;
      entry_open         <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      entry_reject       <= 1'b0;
    end else begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      entry_reject       <= 1'b0;
      if (start) begin
        ent_state  <= E_IDLE;
        entry_open <= 1'b0;
      end else if (started) begin
        case (ent_state)
          E_IDLE: begin
            if (entry_filt) begin
              ent_state    <= E_WAIT_BADGE;
              ent_wait_cnt <= '0;
            end
          end
          E_WAIT_BADGE: begin
            if (!entry_filt) begin
              ent_state <= E_IDLE;
            end else if (badge_valid || ent_wait_cnt == BW_W'(BADGE_WAIT - 1)) begin
              ent_uni <= decide_uni;
              if (decide_ok) begin
                ent_state    <= E_OPEN;
                entry_open   <= 1'b1;
                ent_open_cnt <= '0;
              end else begin
                ent_state    <= E_HOLD;
                entry_reject <= 1'b1;
              end
            end else begin
              ent_wait_cnt <= ent_wait_cnt + 1'b1;
            end
          end
          E_OPEN: begin
            if (entry_rise) begin
              ent_state          <= E_EMIT;
              entry_open         <= 1'b0;
              car_entered        <= 1'b1;
              is_uni_car_entered <= ent_uni;
            end else if (!entry_filt) begin
              ent_state  <= E_IDLE;
              entry_open <= 1'b0;
            end else if (TIMEOUT_EN && ent_open_cnt == OT_W'(OPEN_TIMEOUT - 1)) begin
              ent_state  <= E_HOLD;
              entry_open <= 1'b0;
            end else begin
              ent_open_cnt <= ent_open_cnt + 1'b1;
            end
          end
          E_EMIT: ent_state <= E_CLOSE;
          E_CLOSE, E_HOLD: begin
            if (!entry_filt) ent_state <= E_IDLE;
          end
          default: begin
            ent_state  <= E_IDLE;
            entry_open <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_state         <= X_IDLE;
      ext_open_cnt      <= '0;
      ext_uni           <= 1'b0;
      exit_open         <= 1'b0;
      car_exited        <= 1'b0;
      is_uni_car_exited <= 1'b0;
    end else begin
      car_exited        <= 1'b0;
      is_uni_car_exited <= 1'b0;
      if (start) begin
        ext_state <= X_IDLE;
        exit_open <= 1'b0;
      end else if (started) begin
        case (ext_state)
          X_IDLE: begin
            if (exit_filt) begin
              ext_state    <= X_OPEN;
              exit_open    <= 1'b1;
              ext_uni      <= exit_uni;
              ext_open_cnt <= '0;
            end
          end
          X_OPEN: begin
            if (exit_rise) begin
              ext_state         <= X_EMIT;
              exit_open         <= 1'b0;
              car_exited        <= 1'b1;
              is_uni_car_exited <= ext_uni;
            end else if (!exit_filt) begin
              ext_state <= X_IDLE;
              exit_open <= 1'b0;
            end else if (TIMEOUT_EN && ext_open_cnt == OT_W'(OPEN_TIMEOUT - 1)) begin
              ext_state <= X_CLOSE;
              exit_open <= 1'b0;
            end else begin
              ext_open_cnt <= ext_open_cnt + 1'b1;
            end
          end
          X_EMIT: ext_state <= X_CLOSE;
          X_CLOSE: begin
            if (!exit_filt) ext_state <= X_IDLE;
          end
          default: begin
            ext_state <= X_IDLE;
            exit_open <= 1'b0;
          end
        endcase
      end
    end
  end

  assign presc_wrap = (presc == PS_W'(CLKS_PER_HOUR - 1));

  // A deferred tick keeps waiting while either lane is about to emit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      presc     <= '0;
      hour      <= 5'd8;
      hour_tick <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      hour_tick <= 1'b0;
      if (start) begin
        started   <= 1'b1;
        presc     <= '0;
        hour      <= 5'd8;
        tick_pend <= 1'b0;
      end else if (started) begin
        presc <= presc_wrap ? '0 : presc + 1'b1;
        if ((presc_wrap && hour < 5'd20) || tick_pend) begin
          if (entry_emit_nxt || exit_emit_nxt) begin
            tick_pend <= 1'b1;
          end else begin
            hour_tick <= 1'b1;
            hour      <= hour + 5'd1;
            tick_pend <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: randomized entry/exit traffic
// against timing rules, event scoreboards and an hour-schedule model.

module tb_parking_gate_ctrl;
  localparam int DB       = 4;
  localparam int BW       = 32;
  localparam int OT       = 64;
  localparam int CPH      = 100;
  localparam int LOOP_LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       entry_loop = 1'b0;
  logic       exit_loop = 1'b0;
  logic       entry_pass = 1'b0;
  logic       exit_pass = 1'b0;
  logic       badge_valid = 1'b0;
  logic       badge_uni = 1'b0;
  logic       exit_uni = 1'b0;
  logic       uni_space_ok = 1'b0;
  logic       space_ok = 1'b0;
  logic       entry_open;
  logic       exit_open;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_reject;
  logic       hour_tick;
  logic [4:0] hour;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         s_cyc = 0;
  logic [0:0] exp_q[$];
  logic [0:0] xexp_q[$];
  int         tick_q[$];
  logic       prev_ce = 1'b0;
  logic       prev_cx = 1'b0;

  parking_gate_ctrl #(
    .DEBOUNCE     (DB),
    .BADGE_WAIT   (BW),
    .OPEN_TIMEOUT (OT),
    .CLKS_PER_HOUR(CPH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .entry_loop        (entry_loop),
    .exit_loop         (exit_loop),
    .entry_pass        (entry_pass),
    .exit_pass         (exit_pass),
    .badge_valid       (badge_valid),
    .badge_uni         (badge_uni),
    .exit_uni          (exit_uni),
    .uni_space_ok      (uni_space_ok),
    .space_ok          (space_ok),
    .entry_open        (entry_open),
    .exit_open         (exit_open),
    .car_entered       (car_entered),
    .is_uni_car_entered(is_uni_car_entered),
    .car_exited        (car_exited),
    .is_uni_car_exited (is_uni_car_exited),
    .entry_reject      (entry_reject),
    .hour_tick         (hour_tick),
    .hour              (hour)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every event must be expected, one cycle wide, and never share a cycle with a tick
  always @(negedge clk) begin
    if (car_entered) begin
      check("ent_width", prev_ce, 0);
      if (exp_q.size() == 0) check("ent_unexpected", car_entered, 0);
      else check("ent_class", is_uni_car_entered, exp_q.pop_front());
    end
    if (car_exited) begin
      check("ext_width", prev_cx, 0);
      if (xexp_q.size() == 0) check("ext_unexpected", car_exited, 0);
      else check("ext_class", is_uni_car_exited, xexp_q.pop_front());
    end
    if (hour_tick) begin
      check("tick_vs_event", car_entered | car_exited, 0);
      tick_q.push_back(cyc);
    end
    prev_ce = car_entered;
    prev_cx = car_exited;
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic loop_clear();
    entry_loop = 1'b0;
    exit_loop  = 1'b0;
    wait_cyc(LOOP_LAT + 3);
  endtask

  task automatic entry_open_via_badge(input logic uni);
    entry_loop   = 1'b1;
    uni_space_ok = 1'b1;
    space_ok     = 1'b1;
    wait_cyc(LOOP_LAT + 1 + $urandom_range(0, 10));
    check("open_before_badge", entry_open, 0);
    badge_valid = 1'b1;
    badge_uni   = uni;
    wait_cyc(1);
    badge_valid = 1'b0;
    badge_uni   = ~uni;
    check("open_rise", entry_open, 1);
  endtask

  task automatic pass_entry(input logic cls);
    exp_q.push_back(cls);
    entry_pass = 1'b1;
    wait_cyc(1);
    check("ent_event", car_entered, 1);
    check("ent_barrier_closed", entry_open, 0);
    entry_pass = 1'($urandom_range(0, 1));
    wait_cyc(1);
    check("ent_one_cycle", car_entered, 0);
    entry_pass = 1'b0;
  endtask

  task automatic entry_txn(input logic use_badge, input logic uni, input logic sp, input logic usp);
    logic cls;
    logic ok;
    cls = use_badge & uni;
    ok  = cls ? usp : sp;
    entry_loop   = 1'b1;
    space_ok     = sp;
    uni_space_ok = usp;
    if (use_badge) begin
      wait_cyc(LOOP_LAT + 1 + $urandom_range(0, 15));
      badge_valid = 1'b1;
      badge_uni   = uni;
      wait_cyc(1);
      badge_valid = 1'b0;
      badge_uni   = 1'($urandom_range(0, 1));
    end else begin
      wait_cyc(LOOP_LAT + BW - 1);
      check("to_pre_open", entry_open, 0);
      check("to_pre_reject", entry_reject, 0);
      wait_cyc(1);
    end
    space_ok     = ~space_ok;
    uni_space_ok = ~uni_space_ok;
    check("decide_open", entry_open, 32'(ok));
    check("decide_reject", entry_reject, 32'(!ok));
    if (ok) begin
      wait_cyc($urandom_range(1, 20));
      check("open_held", entry_open, 1);
      pass_entry(cls);
    end else begin
      wait_cyc(1);
      check("reject_one_cycle", entry_reject, 0);
      wait_cyc(10);
      check("reject_stays_closed", entry_open, 0);
    end
    loop_clear();
  endtask

  task automatic exit_txn(input logic u);
    exit_loop = 1'b1;
    exit_uni  = u;
    wait_cyc(LOOP_LAT - 1);
    check("ext_open_early", exit_open, 0);
    wait_cyc(1);
    check("ext_open", exit_open, 1);
    exit_uni = ~u;
    wait_cyc($urandom_range(1, 20));
    xexp_q.push_back(u);
    exit_pass = 1'b1;
    wait_cyc(1);
    check("ext_event", car_exited, 1);
    check("ext_barrier_closed", exit_open, 0);
    exit_pass = 1'b0;
    wait_cyc(1);
    check("ext_one_cycle", car_exited, 0);
    loop_clear();
  endtask

  initial begin
    int n;
    logic u;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    check("rst_entry_open", entry_open, 0);
    check("rst_exit_open", exit_open, 0);
    check("rst_car_entered", car_entered, 0);
    check("rst_car_exited", car_exited, 0);
    check("rst_reject", entry_reject, 0);
    check("rst_tick", hour_tick, 0);
    check("rst_hour", hour, 8);

    // before start: loops and badges ignored, no ticks
    entry_loop  = 1'b1;
    exit_loop   = 1'b1;
    space_ok    = 1'b1;
    uni_space_ok = 1'b1;
    wait_cyc(20);
    badge_valid = 1'b1;
    wait_cyc(1);
    badge_valid = 1'b0;
    wait_cyc(130);
    check("prestart_entry_open", entry_open, 0);
    check("prestart_exit_open", exit_open, 0);
    check("prestart_ticks", tick_q.size(), 0);
    loop_clear();

    do_start();

    // 3-cycle glitch must not qualify; a badge afterwards would otherwise open
    entry_loop = 1'b1;
    wait_cyc(3);
    entry_loop = 1'b0;
    wait_cyc(5);
    badge_valid = 1'b1;
    badge_uni   = 1'b1;
    wait_cyc(1);
    badge_valid = 1'b0;
    wait_cyc(2);
    check("glitch_no_open", entry_open, 0);
    wait_cyc(40);
    check("glitch_no_reject_open", entry_open, 0);

    // directed uni entry, then no-badge entry with lot full
    entry_open_via_badge(1'b1);
    wait_cyc(5);
    pass_entry(1'b1);
    loop_clear();
    entry_txn(1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++)
      entry_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) exit_txn(1'($urandom_range(0, 1)));

    // simultaneous passes on both lanes
    u = 1'($urandom_range(0, 1));
    entry_open_via_badge(1'b1);
    exit_loop = 1'b1;
    exit_uni  = u;
    wait_cyc(LOOP_LAT);
    check("sim_exit_open", exit_open, 1);
    exit_uni = ~u;
    wait_cyc($urandom_range(1, 5));
    exp_q.push_back(1'b1);
    xexp_q.push_back(u);
    entry_pass = 1'b1;
    exit_pass  = 1'b1;
    wait_cyc(1);
    check("sim_entered", car_entered, 1);
    check("sim_exited", car_exited, 1);
    entry_pass = 1'b0;
    exit_pass  = 1'b0;
    wait_cyc(1);
    check("sim_entered_off", car_entered, 0);
    check("sim_exited_off", car_exited, 0);
    loop_clear();

    // open barrier without a pass
    entry_open_via_badge(1'b0);
`ifdef PARKING_GATE_TIMEOUT_EN
    wait_cyc(OT - 1);
    check("timeout_still_open", entry_open, 1);
    wait_cyc(1);
    check("timeout_closed", entry_open, 0);
    check("timeout_no_reject", entry_reject, 0);
    loop_clear();
`else
    wait_cyc(200);
    check("no_timeout_open", entry_open, 1);
    loop_clear();
    check("reverse_closed", entry_open, 0);
`endif

    // start while a pass is being sampled drops the event
    entry_open_via_badge(1'b0);
    wait_cyc(3);
    entry_pass = 1'b1;
    start      = 1'b1;
    wait_cyc(1);
    start      = 1'b0;
    entry_pass = 1'b0;
    check("abort_no_event", car_entered, 0);
    check("abort_closed", entry_open, 0);
    loop_clear();

    // hour schedule 8 -> 20, then silence
    tick_q.delete();
    do_start();
    wait_cyc(3 * CPH + 50);
    check("hour_mid", hour, 11);
    wait_cyc(10 * CPH);
    check("hour_final", hour, 20);
    check("tick_count", tick_q.size(), 12);
    n = (tick_q.size() < 12) ? tick_q.size() : 12;
    for (int k = 0; k < n; k++) check("tick_time", tick_q[k], s_cyc + CPH * (k + 1));

    // wrap landing on an EMIT cycle defers the tick by one
    tick_q.delete();
    do_start();
    entry_open_via_badge(1'b0);
    while (cyc < s_cyc + CPH - 1) wait_cyc(1);
    exp_q.push_back(1'b0);
    entry_pass = 1'b1;
    wait_cyc(1);
    check("defer_event", car_entered, 1);
    check("defer_no_tick", hour_tick, 0);
    entry_pass = 1'b0;
    wait_cyc(1);
    check("defer_tick", hour_tick, 1);
    check("defer_hour", hour, 9);
    entry_loop = 1'b0;
    while (cyc < s_cyc + 2 * CPH + 1) wait_cyc(1);
    if (tick_q.size() < 2) check("defer_tick_count", tick_q.size(), 2);
    else begin
      check("defer_tick_time", tick_q[0], s_cyc + CPH + 1);
      check("next_tick_time", tick_q[1], s_cyc + 2 * CPH);
    end
    loop_clear();

    // async reset during OPEN
    entry_open_via_badge(1'b1);
    wait_cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_entry_open", entry_open, 0);
    check("arst_hour", hour, 8);
    check("arst_car_entered", car_entered, 0);
    entry_loop = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    tick_q.delete();
    wait_cyc(150);
    check("arst_no_ticks", tick_q.size(), 0);
    check("arst_hour_hold", hour, 8);

    check("exp_q_drained", exp_q.size(), 0);
    check("xexp_q_drained", xexp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
